serial_rx: RTL

- Bit-serial receiver for the single-wire, pulled-up, open-drain test line used by the vlog bench models. It is the receive end of the line driven by the existing serial transmitter model.
- The line idles high through a `pullup` primitive. A frame is one low start bit, DATA_BITS data bits (LSB first), and one high stop bit.
- Recovers each data word, presents it on a valid/ready handshake, and flags framing and overrun errors.

---
 rtl/serial_rx_pkg.sv | 24 ++
 rtl/serial_rx_sync2.sv | 25 ++
 rtl/serial_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial_rx receiver and its bench.
package serial_rx_pkg;

  // Default frame geometry of the line driven by the transmitter model.
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 9;

  // Receiver state; WAIT_HIGH holds off re-arming while the line sits low.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Clock edges from a raw line fall (during cycle 0) to the edge that
  // raises out_valid: 2 synchronizer stages, half a start bit, DATA_BITS
  // data bits plus the stop bit, and one edge to register the word.
  function automatic int rx_latency(input int clks_per_bit, input int data_bits);
    return 2 + clks_per_bit / 2 + (data_bits + 1) * clks_per_bit + 1;
  endfunction

endpackage

// File: rtl/serial_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1
// because the line it guards idles high.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to settle metastability.
  // NOTE: every clocked register uses non-blocking (<=) so all flops update
  // from the same pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Bit-serial receiver for the pulled-up single-wire test line: start bit,
// DATA_BITS data bits LSB first, stop bit. Delivers words on a valid/ready
// handshake and pulses frame_err / overrun for bad stop bits and lost words.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 line,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  // Cycle counter gets one spare bit so it can never wrap inside a bit.
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(DATA_BITS - 1);

  // Synchronized line and edge-detect history.
  logic       ls;
  logic       ls_prev;
  logic [1:0] flushed;

  // Registered state and its next-state values.
  state_t                 state,     state_d;
  logic [CW-1:0]          cyc_cnt,   cyc_d;
  logic [BW-1:0]          bit_cnt,   bit_d;
  logic [DATA_BITS-1:0]   shreg,     shreg_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d;
  logic                   ferr_d;
  logic                   ovr_d;

  sync2 u_sync_line (
    .clk   (clk),
    .reset (reset),
    .d     (line),
    .q     (ls)
  );

  // Track the previous synchronized level for fall detection. The
  // synchronizer comes out of reset holding 1s, not the real line, so
  // ls_prev only starts following ls once both stages have been refilled;
  // a line that is stuck low across reset therefore never looks like a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flushed <= 2'b00;
      ls_prev <= 1'b0;
    end else begin
      flushed <= {flushed[0], 1'b1};
      ls_prev <= ls & flushed[1];
    end
  end

  // Next-state, counter, shift-register and output decode.
  // NOTE: every signal gets its hold/default value before the case so no
  // path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state;
    cyc_d   = cyc_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    data_d  = out_data;
    valid_d = out_valid;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A consumed word drops valid unless a new word is loaded below.
    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (ls_prev && !ls) begin
          state_d = START;
          cyc_d   = '0;
        end
      end

      START: begin
        if (cyc_cnt == HALF_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          // Still low at mid start bit: a real frame; otherwise a glitch.
          state_d = ls ? IDLE : DATA;
        end else begin
          cyc_d = cyc_cnt + CW'(1);
        end
      end

      DATA: begin
        if (cyc_cnt == BIT_LAST) begin
          cyc_d = '0;
          // New bit enters the MSB so the first bit ends at the LSB.
          shreg_d                = shreg >> 1;
          shreg_d[DATA_BITS-1]   = ls;
          if (bit_cnt == WORD_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_cnt + BW'(1);
          end
        end else begin
          cyc_d = cyc_cnt + CW'(1);
        end
      end

      STOP: begin
        if (cyc_cnt == BIT_LAST) begin
          cyc_d = '0;
          if (ls) begin
            state_d = IDLE;
            if (!out_valid || out_ready) begin
              data_d  = shreg;
              valid_d = 1'b1;
            end else begin
              // Previous word still pending: keep it, drop the new one.
              ovr_d = 1'b1;
            end
          end else begin
            // Stop bit low (bad frame or break): drop the word and wait
            // for the line to return high before re-arming.
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cyc_d = cyc_cnt + CW'(1);
        end
      end

      WAIT_HIGH: begin
        if (ls) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      cyc_cnt   <= cyc_d;
      bit_cnt   <= bit_d;
      shreg     <= shreg_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
    end
  end

  assign busy = (state != IDLE);

endmodule
